// File: rtl/mc_datapath_regs_if.sv
// Bundle of the datapath register bank's control strobes, data inputs and
// register/decoded-field outputs.
//   master : control FSM / ALU / memory / register file side (drives strobes and data)
//   slave  : register bank side (drives pc, ir, fields, operand regs, status)
interface mc_datapath_regs_if #(
   parameter int CNT_W = 32
);
   logic             pc_write;
   logic             pc_write_cond;
   logic             pc_cond_src;
   logic [1:0]       pc_source;
   logic             ir_write;
   logic             iord;
   logic [31:0]      alu_result;
   logic             alu_zero;
   logic [31:0]      mem_rdata;
   logic [31:0]      rf_rdata1;
   logic [31:0]      rf_rdata2;

   logic [31:0]      pc;
   logic [31:0]      mem_addr;
   logic [31:0]      ir;
   logic [5:0]       op;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [4:0]       shamt;
   logic [5:0]       funct;
   logic [31:0]      imm_sext;
   logic [31:0]      mdr;
   logic [31:0]      a;
   logic [31:0]      b;
   logic [31:0]      alu_out;
   logic             align_err;
   logic [CNT_W-1:0] inst_count;

   modport master (
      output pc_write, pc_write_cond, pc_cond_src, pc_source, ir_write, iord,
             alu_result, alu_zero, mem_rdata, rf_rdata1, rf_rdata2,
      input  pc, mem_addr, ir, op, rs, rt, rd, shamt, funct, imm_sext,
             mdr, a, b, alu_out, align_err, inst_count
   );

   modport slave (
      input  pc_write, pc_write_cond, pc_cond_src, pc_source, ir_write, iord,
             alu_result, alu_zero, mem_rdata, rf_rdata1, rf_rdata2,
      output pc, mem_addr, ir, op, rs, rt, rd, shamt, funct, imm_sext,
             mdr, a, b, alu_out, align_err, inst_count
   );
endinterface

// File: rtl/mc_datapath_regs.sv
// Inter-cycle register bank of the multi-cycle MIPS datapath.
// Holds PC, IR, MDR, A, B and ALUOut, applies the control FSM's PC/IR write
// strobes, supplies the memory address and decoded IR fields, flags any
// misaligned PC write (sticky) and counts instruction fetches.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mc_datapath_regs_if.slave (strobes/data in, registers/fields out)
module mc_datapath_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input logic              clk,
   input logic              rst,
   mc_datapath_regs_if.slave bus
);

   logic        take_branch;
   logic        pc_en;
   logic        src_valid;
   logic [31:0] next_pc;

   always_comb begin
      take_branch = bus.pc_cond_src ? bus.alu_zero : ~bus.alu_zero;
      pc_en       = bus.pc_write | (bus.pc_write_cond & take_branch);
      src_valid   = 1'b1;
      next_pc     = bus.alu_result;
      case (bus.pc_source)
         2'b00:   next_pc = bus.alu_result;
         2'b01:   next_pc = bus.alu_out;
         2'b10:   next_pc = {bus.pc[31:28], bus.ir[25:0], 2'b00};
         default: begin
            // reserved encoding: PC holds silently
            next_pc   = bus.pc;
            src_valid = 1'b0;
         end
      endcase
   end

   assign bus.mem_addr = bus.iord ? bus.alu_out : bus.pc;

   assign bus.op       = bus.ir[31:26];
   assign bus.rs       = bus.ir[25:21];
   assign bus.rt       = bus.ir[20:16];
   assign bus.rd       = bus.ir[15:11];
   assign bus.shamt    = bus.ir[10:6];
   assign bus.funct    = bus.ir[5:0];
   assign bus.imm_sext = {{16{bus.ir[15]}}, bus.ir[15:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.pc         <= RESET_PC;
         bus.ir         <= '0;
         bus.mdr        <= '0;
         bus.a          <= '0;
         bus.b          <= '0;
         bus.alu_out    <= '0;
         bus.align_err  <= 1'b0;
         bus.inst_count <= '0;
      end else begin
         bus.mdr     <= bus.mem_rdata;
         bus.a       <= bus.rf_rdata1;
         bus.b       <= bus.rf_rdata2;
         bus.alu_out <= bus.alu_result;
         // on a fetch IR captures data addressed by the pre-update PC
         if (bus.ir_write) begin
            bus.ir         <= bus.mem_rdata;
            bus.inst_count <= bus.inst_count + CNT_W'(1);
         end
         if (pc_en && src_valid) begin
            bus.pc <= {next_pc[31:2], 2'b00};
            if (next_pc[1:0] != 2'b00) begin
               bus.align_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mc_datapath_regs.sv
module tb_mc_datapath_regs;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          CW     = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mc_datapath_regs_if #(.CNT_W(CW)) bus ();

   mc_datapath_regs #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference state
   logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
   logic        m_err;
   int          m_cnt;

   task automatic idle_inputs();
      bus.pc_write = 0; bus.pc_write_cond = 0; bus.pc_cond_src = 0;
      bus.pc_source = 2'b00; bus.ir_write = 0; bus.iord = 0;
      bus.alu_result = 0; bus.alu_zero = 0; bus.mem_rdata = 0;
      bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
      m_err = 0; m_cnt = 0;
   endtask

   // assert reset mid-cycle, release on the following falling edge
   task automatic pulse_reset();
      idle_inputs();
      #2 rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // one rising edge; the reference advances from the inputs currently driven
   task automatic tick();
      logic [31:0] tgt;
      logic        taken, src_ok;
      taken  = bus.pc_write || (bus.pc_write_cond && (bus.pc_cond_src == bus.alu_zero));
      src_ok = 1'b1;
      tgt    = m_pc;
      if (bus.pc_source == 2'd0)      tgt = bus.alu_result;
      else if (bus.pc_source == 2'd1) tgt = m_aluout;
      else if (bus.pc_source == 2'd2) tgt = (m_pc & 32'hF000_0000) + (m_ir % 32'h0400_0000) * 4;
      else                            src_ok = 1'b0;
      @(posedge clk);
      #1;
      if (taken && src_ok) begin
         m_pc = tgt - (tgt % 4);
         if (tgt % 4 != 0) m_err = 1'b1;
      end
      if (bus.ir_write) begin
         m_ir  = bus.mem_rdata;
         m_cnt = (m_cnt + 1) % (1 << CW);
      end
      m_mdr = bus.mem_rdata; m_a = bus.rf_rdata1; m_b = bus.rf_rdata2;
      m_aluout = bus.alu_result;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.mem_rdata = 32'hDEAD_BEEF; bus.ir_write = 1; bus.pc_write = 1;
      bus.alu_result = 32'h0000_0ABC;
      tick();
      tick();
      pulse_reset();
      checks++;
      if (bus.pc !== 32'h100 || bus.ir !== 0 || bus.inst_count !== 0 || bus.align_err !== 0 ||
          bus.mdr !== 0 || bus.alu_out !== 0) begin
         errors++;
         $display("FAIL reset: pc=%h ir=%h cnt=%0d err=%b mdr=%h aluout=%h, expected pc=100 rest zero",
                  bus.pc, bus.ir, bus.inst_count, bus.align_err, bus.mdr, bus.alu_out);
      end
   endtask

   task automatic test_fetch();
      idle_inputs();
      #1;
      checks++;
      if (bus.mem_addr !== 32'h100) begin
         errors++; $display("FAIL fetch_addr: got %h expected 00000100", bus.mem_addr);
      end
      bus.mem_rdata = 32'h8C43_0004; bus.ir_write = 1; bus.pc_write = 1;
      bus.alu_result = 32'h104;
      tick();
      checks++;
      if (bus.ir !== 32'h8C43_0004 || bus.op !== 6'h23 || bus.imm_sext !== 32'h4 ||
          bus.pc !== 32'h104 || bus.inst_count !== 1 || bus.rs !== 5'd2 || bus.rt !== 5'd3) begin
         errors++;
         $display("FAIL fetch: ir=%h op=%h imm=%h pc=%h cnt=%0d, expected 8c430004 23 00000004 00000104 1",
                  bus.ir, bus.op, bus.imm_sext, bus.pc, bus.inst_count);
      end
   endtask

   task automatic test_branch();
      idle_inputs();
      bus.alu_result = 32'h200;
      tick();
      // taken BEQ; alu_out moves on to 0x300 for the next cycles
      bus.pc_write_cond = 1; bus.pc_source = 2'b01; bus.pc_cond_src = 1; bus.alu_zero = 1;
      bus.alu_result = 32'h300;
      tick();
      checks++;
      if (bus.pc !== 32'h200) begin errors++; $display("FAIL beq_taken: pc=%h expected 00000200", bus.pc); end
      bus.alu_zero = 0;
      tick();
      checks++;
      if (bus.pc !== 32'h200) begin errors++; $display("FAIL beq_not_taken: pc=%h expected 00000200", bus.pc); end
      bus.pc_cond_src = 0; bus.alu_zero = 0; bus.alu_result = 32'h400;
      tick();
      checks++;
      if (bus.pc !== 32'h300) begin errors++; $display("FAIL bne_taken: pc=%h expected 00000300", bus.pc); end
      // not-taken branch but unconditional write also set
      bus.alu_zero = 1; bus.pc_write = 1;
      tick();
      checks++;
      if (bus.pc !== 32'h400) begin errors++; $display("FAIL write_wins: pc=%h expected 00000400", bus.pc); end
   endtask

   task automatic test_jump();
      idle_inputs();
      bus.mem_rdata = 32'h0800_0040; bus.ir_write = 1; bus.pc_write = 1;
      bus.alu_result = 32'h4000_0010;
      tick();
      idle_inputs();
      bus.pc_write = 1; bus.pc_source = 2'b10;
      tick();
      checks++;
      if (bus.pc !== 32'h4000_0100) begin errors++; $display("FAIL jump: pc=%h expected 40000100", bus.pc); end
   endtask

   task automatic test_misalign_reserved();
      pulse_reset();
      bus.pc_write = 1; bus.alu_result = 32'h102;
      tick();
      checks++;
      if (bus.pc !== 32'h100 || bus.align_err !== 1'b1) begin
         errors++; $display("FAIL misalign: pc=%h err=%b expected 00000100 1", bus.pc, bus.align_err);
      end
      bus.alu_result = 32'h208;
      tick();
      checks++;
      if (bus.pc !== 32'h208 || bus.align_err !== 1'b1) begin
         errors++; $display("FAIL sticky: pc=%h err=%b expected 00000208 1", bus.pc, bus.align_err);
      end
      bus.pc_source = 2'b11; bus.alu_result = 32'h555;
      tick();
      checks++;
      if (bus.pc !== 32'h208) begin errors++; $display("FAIL reserved: pc=%h expected 00000208", bus.pc); end
   endtask

   task automatic test_addr_wrap();
      idle_inputs();
      bus.alu_result = 32'h80;
      tick();
      bus.iord = 1;
      #1;
      checks++;
      if (bus.mem_addr !== 32'h80) begin errors++; $display("FAIL iord_addr: got %h expected 00000080", bus.mem_addr); end
      pulse_reset();
      bus.ir_write = 1;
      for (int i = 0; i < 15; i++) begin
         bus.mem_rdata = 32'h1000 + i;
         tick();
      end
      checks++;
      if (bus.inst_count !== 4'd15) begin errors++; $display("FAIL cnt_max: got %0d expected 15", bus.inst_count); end
      tick();
      checks++;
      if (bus.inst_count !== 4'd0) begin errors++; $display("FAIL cnt_wrap: got %0d expected 0", bus.inst_count); end
   endtask

   task automatic test_random();
      logic [31:0] ea;
      pulse_reset();
      for (int n = 0; n < 400; n++) begin
         if (n == 200) pulse_reset();
         bus.pc_write      = ($urandom_range(0, 3) == 0);
         bus.pc_write_cond = $urandom_range(0, 1);
         bus.pc_cond_src   = $urandom_range(0, 1);
         bus.alu_zero      = $urandom_range(0, 1);
         bus.pc_source     = 2'($urandom_range(0, 3));
         bus.ir_write      = $urandom_range(0, 1);
         bus.iord          = $urandom_range(0, 1);
         bus.alu_result    = $urandom;
         if ($urandom_range(0, 7) != 0) bus.alu_result = bus.alu_result & 32'hFFFF_FFFC;
         bus.mem_rdata     = $urandom;
         bus.rf_rdata1     = $urandom;
         bus.rf_rdata2     = $urandom;
         #1;
         ea = bus.iord ? m_aluout : m_pc;
         checks++;
         if (bus.mem_addr !== ea) begin
            errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, bus.mem_addr, ea);
         end
         tick();
         checks++;
         if (bus.pc !== m_pc || bus.ir !== m_ir || bus.mdr !== m_mdr || bus.a !== m_a ||
             bus.b !== m_b || bus.alu_out !== m_aluout || bus.align_err !== m_err ||
             int'(bus.inst_count) != m_cnt) begin
            errors++;
            $display("FAIL rnd_regs[%0d]: pc=%h/%h ir=%h/%h mdr=%h/%h a=%h/%h b=%h/%h ao=%h/%h err=%b/%b cnt=%0d/%0d (got/expected)",
                     n, bus.pc, m_pc, bus.ir, m_ir, bus.mdr, m_mdr, bus.a, m_a, bus.b, m_b,
                     bus.alu_out, m_aluout, bus.align_err, m_err, bus.inst_count, m_cnt);
         end
         checks++;
         if (bus.op !== 6'(m_ir >> 26) || bus.rs !== 5'((m_ir >> 21) % 32) ||
             bus.rt !== 5'((m_ir >> 16) % 32) || bus.rd !== 5'((m_ir >> 11) % 32) ||
             bus.shamt !== 5'((m_ir >> 6) % 32) || bus.funct !== 6'(m_ir % 64) ||
             bus.imm_sext !== 32'($signed(m_ir[15:0]))) begin
            errors++;
            $display("FAIL rnd_fields[%0d]: ir=%h op=%h rs=%h rt=%h rd=%h sh=%h fn=%h imm=%h",
                     n, m_ir, bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.imm_sext);
         end
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst = 1'b1;
      #12 rst = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_fetch();
      test_branch();
      test_jump();
      test_misalign_reserved();
      test_addr_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
